// File: rtl/gx_fifo_pkg.sv
// Shared constants and state encoding for the GX command-ring line writer.
// Optional high-watermark logic is enabled with GX_FIFO_HIWATER_EN.
package gx_fifo_pkg;

    localparam int LINE_BYTES = 32;
    localparam int BEATS      = 4;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] BEAT_SIZE  = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/gx_fifo_ring_ptr.sv
// Ring write pointer: wrap arithmetic, deferred load while busy, optional hi_irq.
// GX_FIFO_HIWATER_EN adds rptr/hi_mark/hi_irq; hi_irq lags pointer changes by one cycle.
module gx_fifo_ring_ptr
    import gx_fifo_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fifo_base,
    input  logic [ADDR_W-1:0] fifo_end,
    input  logic              idle,
    input  logic              advance,
    input  logic              wptr_load,
    input  logic [ADDR_W-1:0] wptr_load_val,
    output logic [ADDR_W-1:0] wptr,
    output logic              load_pending
`ifdef GX_FIFO_HIWATER_EN
    ,
    input  logic [ADDR_W-1:0] rptr,
    input  logic [ADDR_W-1:0] hi_mark,
    output logic              hi_irq
`endif
);

    logic [ADDR_W-1:0] load_aligned;
    logic [ADDR_W-1:0] next_ptr;
    logic [ADDR_W-1:0] pend_val;

    assign load_aligned = wptr_load_val & ~ADDR_W'(LINE_BYTES - 1);
    // Wrap compares literally against end, even for a misconfigured base > end.
    assign next_ptr     = (wptr >= fifo_end) ? fifo_base : wptr + ADDR_W'(LINE_BYTES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr         <= '0;
            load_pending <= 1'b0;
            pend_val     <= '0;
        end else if (advance) begin
            load_pending <= 1'b0;
            if (wptr_load) begin
                wptr <= load_aligned;
            end else if (load_pending) begin
                wptr <= pend_val;
            end else begin
                wptr <= next_ptr;
            end
        end else if (wptr_load) begin
            if (idle) begin
                wptr <= load_aligned;
            end else begin
                load_pending <= 1'b1;
                pend_val     <= load_aligned;
            end
        end
    end

`ifdef GX_FIFO_HIWATER_EN
    logic [ADDR_W-1:0] ring_bytes;
    logic [ADDR_W-1:0] distance;

    assign ring_bytes = fifo_end - fifo_base + ADDR_W'(LINE_BYTES);
    assign distance   = (wptr >= rptr) ? (wptr - rptr) : (ring_bytes - (rptr - wptr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_irq <= 1'b0;
        end else begin
            hi_irq <= (distance >= hi_mark);
        end
    end
`endif

endmodule

// File: rtl/gx_fifo_line_writer.sv
// Writes each 32-byte gathered line as one 4-beat AXI INCR burst into the GX ring; >= 6 cycles/line.
// line_ready is held low from accept until B completes; GX_FIFO_HIWATER_EN adds the hi_irq ports.
module gx_fifo_line_writer
    import gx_fifo_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [255:0]      line_data,
    input  logic              line_valid,
    output logic              line_ready,
    input  logic [ADDR_W-1:0] fifo_base,
    input  logic [ADDR_W-1:0] fifo_end,
    input  logic              wptr_load,
    input  logic [ADDR_W-1:0] wptr_load_val,
    output logic [ADDR_W-1:0] wptr,
    output logic              busy,
    output logic              bus_err,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [63:0]       m_axi_wdata,
    output logic [7:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready
`ifdef GX_FIFO_HIWATER_EN
    ,
    input  logic [ADDR_W-1:0] rptr,
    input  logic [ADDR_W-1:0] hi_mark,
    output logic              hi_irq
`endif
);

    state_t            state;
    logic [255:0]      line_buf;
    logic [ADDR_W-1:0] awaddr_q;
    logic              aw_done;
    logic              w_done;
    logic [1:0]        beat;

    logic idle;
    logic accept;
    logic aw_hs;
    logic w_hs;
    logic last_hs;
    logic burst_done;
    logic resp_done;
    logic load_pending;

    assign idle       = (state == IDLE);
    assign line_ready = idle && !load_pending && !wptr_load && !reset;
    assign accept     = line_valid && line_ready;
    assign busy       = !idle;

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'(BEATS - 1);
    assign m_axi_awsize  = BEAT_SIZE;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awvalid = (state == BURST) && !aw_done;

    // W runs independently of AW; w_done parks the channel once beat 3 is taken.
    assign m_axi_wvalid = (state == BURST) && !w_done;
    assign m_axi_wdata  = line_buf[{beat, 6'b0} +: 64];
    assign m_axi_wstrb  = 8'hFF;
    assign m_axi_wlast  = m_axi_wvalid && (beat == 2'(BEATS - 1));
    assign m_axi_bready = (state == RESP);

    assign aw_hs      = m_axi_awvalid && m_axi_awready;
    assign w_hs       = m_axi_wvalid && m_axi_wready;
    assign last_hs    = w_hs && (beat == 2'(BEATS - 1));
    assign burst_done = (aw_done || aw_hs) && (w_done || last_hs);
    assign resp_done  = m_axi_bready && m_axi_bvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            line_buf <= '0;
            awaddr_q <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            beat     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        line_buf <= line_data;
                        awaddr_q <= wptr;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        beat     <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        beat <= beat + 2'd1;
                    end
                    if (last_hs) begin
                        w_done <= 1'b1;
                    end
                    if (burst_done) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A new error outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if (resp_done && (m_axi_bresp != RESP_OKAY)) begin
            bus_err <= 1'b1;
        end else if (err_clr) begin
            bus_err <= 1'b0;
        end
    end

    gx_fifo_ring_ptr #(
        .ADDR_W (ADDR_W)
    ) u_ring_ptr (
        .clk           (clk),
        .reset         (reset),
        .fifo_base     (fifo_base),
        .fifo_end      (fifo_end),
        .idle          (idle),
        .advance       (resp_done),
        .wptr_load     (wptr_load),
        .wptr_load_val (wptr_load_val),
        .wptr          (wptr),
        .load_pending  (load_pending)
`ifdef GX_FIFO_HIWATER_EN
        ,
        .rptr          (rptr),
        .hi_mark       (hi_mark),
        .hi_irq        (hi_irq)
`endif
    );

endmodule

// File: tb/tb_gx_fifo_line_writer.sv
// Scoreboard bench for gx_fifo_line_writer: directed lines, AXI slave model, monitor checks AW/W.
module tb_gx_fifo_line_writer;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] line_data;
    logic         line_valid;
    logic         line_ready;
    logic [31:0]  fifo_base;
    logic [31:0]  fifo_end;
    logic         wptr_load;
    logic [31:0]  wptr_load_val;
    logic [31:0]  wptr;
    logic         busy;
    logic         bus_err;
    logic         err_clr;
    logic [31:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_awvalid;
    logic         m_axi_awready;
    logic [63:0]  m_axi_wdata;
    logic [7:0]   m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready;
    logic [1:0]   m_axi_bresp;
    logic         m_axi_bvalid;
    logic         m_axi_bready;
`ifdef GX_FIFO_HIWATER_EN
    logic [31:0]  rptr    = '0;
    logic [31:0]  hi_mark = 32'hFFFF_FFFF;
    logic         hi_irq;
`endif

    gx_fifo_line_writer #(.ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .line_data     (line_data),
        .line_valid    (line_valid),
        .line_ready    (line_ready),
        .fifo_base     (fifo_base),
        .fifo_end      (fifo_end),
        .wptr_load     (wptr_load),
        .wptr_load_val (wptr_load_val),
        .wptr          (wptr),
        .busy          (busy),
        .bus_err       (bus_err),
        .err_clr       (err_clr),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
`ifdef GX_FIFO_HIWATER_EN
        ,
        .rptr          (rptr),
        .hi_mark       (hi_mark),
        .hi_irq        (hi_irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_aw[$];
    logic [64:0] exp_w[$];

    int          aw_delay  = 0;
    bit          w_toggle  = 1'b0;
    logic [1:0]  bresp_sel = 2'b00;
    int          aw_cnt    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AXI slave: AW held off aw_delay cycles, W optionally toggled, B answers one cycle after bready.
    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (m_axi_awvalid) begin
                if (aw_cnt >= aw_delay) begin
                    m_axi_awready = 1'b1;
                end else begin
                    m_axi_awready = 1'b0;
                    aw_cnt++;
                end
            end else begin
                m_axi_awready = 1'b0;
                aw_cnt        = 0;
            end
            m_axi_wready = w_toggle ? ~m_axi_wready : 1'b1;
            m_axi_bvalid = m_axi_bready;
            m_axi_bresp  = m_axi_bready ? bresp_sel : 2'b00;
        end
    end

    // Monitor: every AW/W handshake about to complete is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (m_axi_awvalid && m_axi_awready) begin
                    if (exp_aw.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL aw_unexpected actual=%h expected=none", m_axi_awaddr);
                    end else begin
                        check("awaddr", 64'(m_axi_awaddr), 64'(exp_aw.pop_front()));
                    end
                    check("awlen", 64'(m_axi_awlen), 64'd3);
                    check("awsize", 64'(m_axi_awsize), 64'd3);
                    check("awburst", 64'(m_axi_awburst), 64'd1);
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    if (exp_w.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL w_unexpected actual=%h expected=none", m_axi_wdata);
                    end else begin
                        logic [64:0] e;
                        e = exp_w.pop_front();
                        check("wdata", m_axi_wdata, e[63:0]);
                        check("wlast", 64'(m_axi_wlast), 64'(e[64]));
                    end
                    check("wstrb", 64'(m_axi_wstrb), 64'hFF);
                end
            end
        end
    end

    // Line words are seed+0 .. seed+7; beat b carries {word 2b+1, word 2b}.
    task automatic start_line(input logic [31:0] addr, input logic [31:0] seed);
        logic [255:0] ld;
        logic [31:0]  lo;
        logic [31:0]  hi;
        int           n;
        for (int b = 0; b < 4; b++) begin
            lo = seed + 32'(2 * b);
            hi = seed + 32'(2 * b + 1);
            ld[64*b +: 64] = {hi, lo};
            exp_w.push_back({(b == 3), hi, lo});
        end
        exp_aw.push_back(addr);
        line_data  = ld;
        line_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!line_ready && n < 50);
        if (!line_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=line_ready_low expected=line_ready_high");
        end
        tick();
        line_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit rdy_busy);
        cyc      = 0;
        rdy_busy = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy && line_ready) rdy_busy = 1'b1;
        end while (busy && cyc < 200);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=busy expected=idle");
        end
        tick();
    endtask

    task automatic do_load(input logic [31:0] val);
        wptr_load     = 1'b1;
        wptr_load_val = val;
        tick();
        wptr_load = 1'b0;
    endtask

    initial begin
        int cyc;
        bit rb;
        reset         = 1'b1;
        line_data     = '0;
        line_valid    = 1'b0;
        fifo_base     = '0;
        fifo_end      = '0;
        wptr_load     = 1'b0;
        wptr_load_val = '0;
        err_clr       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_wptr", 64'(wptr), 64'h0);
        check("rst_bus_err", 64'(bus_err), 64'h0);
        check("rst_awvalid", 64'(m_axi_awvalid), 64'h0);
        check("rst_wvalid", 64'(m_axi_wvalid), 64'h0);
        check("rst_wlast", 64'(m_axi_wlast), 64'h0);
        check("rst_bready", 64'(m_axi_bready), 64'h0);
        check("rst_line_ready", 64'(line_ready), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);

        tick();
        reset     = 1'b0;
        fifo_base = 32'h1000;
        fifo_end  = 32'h1060;
        do_load(32'h1000);
        @(negedge clk);
        check("load_idle_wptr", 64'(wptr), 64'h1000);
        check("idle_line_ready", 64'(line_ready), 64'h1);
        tick();

        // First line, AXI always ready: 6 cycles accept-to-ready
        start_line(32'h1000, 32'h0);
        wait_done(cyc, rb);
        check("line_cycles", 64'(cyc), 64'd6);
        check("wptr_line1", 64'(wptr), 64'h1020);

        // Wrap through four slots
        do_load(32'h1000);
        for (int i = 0; i < 4; i++) begin
            start_line(32'h1000 + 32'(32 * i), 32'(32'h100 * (i + 1)));
            wait_done(cyc, rb);
            check("wptr_wrap", 64'(wptr), (i == 3) ? 64'h1000 : 64'(32'h1000 + 32'(32 * (i + 1))));
        end

        // Backpressure on AW and W
        aw_delay = 5;
        w_toggle = 1'b1;
        start_line(32'h1000, 32'h500);
        wait_done(cyc, rb);
        check("ready_while_busy", 64'(rb), 64'h0);
        check("wptr_backpressure", 64'(wptr), 64'h1020);
        aw_delay = 0;
        w_toggle = 1'b0;

        // Pointer load while a burst is in flight
        fifo_base = 32'h2000;
        fifo_end  = 32'h20E0;
        aw_delay  = 3;
        start_line(32'h1020, 32'h600);
        tick();
        do_load(32'h2005);
        check("wptr_hold_busy", 64'(wptr), 64'h1020);
        wait_done(cyc, rb);
        check("ready_while_pending", 64'(rb), 64'h0);
        check("wptr_pending_load", 64'(wptr), 64'h2000);
        aw_delay = 0;
        start_line(32'h2000, 32'h700);
        wait_done(cyc, rb);
        check("wptr_after_load", 64'(wptr), 64'h2020);

        // Error response: sticky, pointer still advances
        bresp_sel = 2'b10;
        start_line(32'h2020, 32'h800);
        wait_done(cyc, rb);
        check("bus_err_set", 64'(bus_err), 64'h1);
        check("wptr_on_err", 64'(wptr), 64'h2040);
        bresp_sel = 2'b00;
        start_line(32'h2040, 32'h900);
        wait_done(cyc, rb);
        check("bus_err_sticky", 64'(bus_err), 64'h1);
        check("wptr_after_err", 64'(wptr), 64'h2060);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("bus_err_clr", 64'(bus_err), 64'h0);

        // Load and line_valid in the same idle cycle: load wins
        wptr_load     = 1'b1;
        wptr_load_val = 32'h2080;
        line_valid    = 1'b1;
        @(negedge clk);
        check("ready_during_load", 64'(line_ready), 64'h0);
        tick();
        wptr_load = 1'b0;
        check("wptr_load_wins", 64'(wptr), 64'h2080);
        start_line(32'h2080, 32'hA00);
        wait_done(cyc, rb);
        check("wptr_after_collide", 64'(wptr), 64'h20A0);

        // Reset after beat 1 abandons the burst
        start_line(32'h20A0, 32'hB00);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_awvalid", 64'(m_axi_awvalid), 64'h0);
        check("async_wvalid", 64'(m_axi_wvalid), 64'h0);
        check("aw_consumed", 64'(exp_aw.size()), 64'd0);
        check("beats_before_reset", 64'(exp_w.size()), 64'd2);
        exp_w.delete();
        @(negedge clk);
        check("mid_rst_wptr", 64'(wptr), 64'h0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(line_ready), 64'h1);

        check("aw_queue_empty", 64'(exp_aw.size()), 64'd0);
        check("w_queue_empty", 64'(exp_w.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
